// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receiver.
// The PARITY state is present only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    PARITY,
    STOP_CHK,
    LOAD
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;
`endif

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value.
module rx_sync_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall_edge
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle-high line level so release never fakes a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out  = sync_q;
  assign fall_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start validation, LSB-first data capture, stop check and
// a one-entry output register. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 parity_error
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_ok;
  logic                 sync_out;
  logic                 fall_edge;
  logic                 half_done;
  logic                 bit_done;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  rx_sync_edge u_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (serial_in),
    .sync_out (sync_out),
    .fall_edge(fall_edge)
  );

  assign half_done = (timer == HALF_LAST);
  assign bit_done  = (timer == FULL_LAST);

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      stop_ok       <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      // Consumer acknowledge; a good LOAD below overrides it in the same cycle.
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall_edge) begin
            state         <= START_CHK;
            timer         <= '0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
          end
        end

        START_CHK: begin
          if (half_done) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= sync_out ? IDLE : RECV;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RECV: begin
          if (bit_done) begin
            timer     <= '0;
            shift_reg <= {sync_out, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP_CHK;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            timer      <= '0;
            parity_bad <= sync_out ^ (^shift_reg);
            state      <= STOP_CHK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        STOP_CHK: begin
          if (bit_done) begin
            timer   <= '0;
            stop_ok <= sync_out;
            state   <= LOAD;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        LOAD: begin
          state <= IDLE;
          if (stop_ok) begin
            rx_data       <= shift_reg;
            data_ready    <= 1'b1;
            overrun_error <= data_ready & ~data_read;
`ifdef UART_RX_PARITY_EN
            parity_error  <= parity_bad;
`endif
          end else begin
            framing_error <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core (CLKS_PER_BIT=10, DATA_BITS=8);
// follows UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx_core;

  localparam int CPB  = 10;
  localparam int NB   = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edges from the serial falling edge to data_ready becoming visible.
  localparam int LAT = 2 + HALF + (NB + 1 + PBITS) * CPB + 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          serial_in;
  logic          data_read;
  logic [NB-1:0] rx_data;
  logic          data_ready;
  logic          overrun_error;
  logic          framing_error;
  logic          parity_error;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_rx;
  logic       m_ready;
  logic       m_over;
  logic       m_frame;
  logic       m_par;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (NB)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rx_data"},       rx_data,       m_rx);
    chk({tag, "/data_ready"},    data_ready,    m_ready);
    chk({tag, "/overrun_error"}, overrun_error, m_over);
    chk({tag, "/framing_error"}, framing_error, m_frame);
    chk({tag, "/parity_error"},  parity_error,  m_par);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    cycles(n);
  endtask

  task automatic ack();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_over  = 1'b0;
  endtask

  // Drives one whole frame; the line is left at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                            input bit read_at_load, input bit chk_lat);
    logic bits[$];
    int   cyc;
    bits.push_back(1'b0);
    for (int i = 0; i < NB; i++) bits.push_back(d[i]);
    if (PBITS == 1) bits.push_back((^d) ^ bad_par);
    bits.push_back(stop);
    m_frame = 1'b0;
    m_par   = 1'b0;
    cyc = 0;
    foreach (bits[k]) begin
      serial_in = bits[k];
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        cyc++;
        if (read_at_load && cyc == LAT - 1) data_read = 1'b1;
        if (read_at_load && cyc == LAT)     data_read = 1'b0;
        if (chk_lat && cyc == LAT - 1) chk("latency_before", data_ready, m_ready);
        if (chk_lat && cyc == LAT)     chk("latency_at", data_ready, stop);
      end
    end
    if (stop) begin
      if (read_at_load) m_over = 1'b0;
      if (m_ready && !read_at_load) m_over = 1'b1;
      m_rx    = d;
      m_ready = 1'b1;
      if (PBITS == 1) m_par = bad_par;
    end else begin
      m_frame = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       bp;
    bit         rl;

    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    m_rx = '0; m_ready = 0; m_over = 0; m_frame = 0; m_par = 0;
    cycles(3);
    check_all("reset");
    n_rst = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    check_all("frame_a5");
    ack();
    cycles(1);
    check_all("ack_a5");

    // Framing error, then a line held low must not retrigger reception.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(50);
    check_all("hold_low_3c");
    idle(5);
    check_all("frame_3c");

    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_all("frame_11");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_all("overrun_22");
    ack();
    cycles(1);
    check_all("ack_overrun");
    ack();
    cycles(1);
    check_all("ack_idle");

    serial_in = 1'b0;
    cycles(3);
    idle(30);
    check_all("glitch");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_all("frame_5a");

    // Acknowledge lands in the LOAD cycle while a previous byte is unread.
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    check_all("load_with_read");

    // Reset mid-frame at data bit 4.
    d = 8'h96;
    serial_in = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      cycles(CPB);
    end
    n_rst     = 1'b0;
    serial_in = 1'b1;
    cycles(2);
    m_rx = '0; m_ready = 0; m_over = 0; m_frame = 0; m_par = 0;
    check_all("reset_mid");
    cycles(3);
    n_rst = 1'b1;
    idle(2 * CPB * (NB + 2));
    check_all("after_reset");
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_all("frame_ff");
    ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_all("parity_bad_07");
    ack();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_all("parity_good_07");
    ack();
`endif

    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      bp   = 1'($urandom_range(0, 1));
      rl   = stop && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) ack();
      send_frame(d, stop, bp, rl, 1'b0);
      idle(2 + $urandom_range(0, 3));
      check_all($sformatf("random_%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
